// File: rtl/clint_timer_resp.sv
// CLINT timer slave: toggle-handshake access to mtime/mtimecmp plus a registered timer interrupt.
// Define CLINT_PRESCALE_EN to advance mtime once every PRESCALE_DIV clk_timer cycles.
module clint_timer_resp #(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic        clk_timer,
  input  logic        rst,
  input  logic        req_tgl,
  input  logic        req_we,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack_tgl,
  output logic [31:0] rsp_rdata,
  output logic        timer_irq,
  output logic [31:0] mtime_lo,
  output logic [31:0] mtime_hi
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state;
  logic            req_s1;
  logic            req_s2;
  logic            req_seen;
  logic [TW-1:0]   mtime;
  logic [TW-1:0]   mtimecmp;
  logic [DW-1:0]   hi_snap;
  logic            snap_vld;
  logic [DW-1:0]   rd_stage;
  logic            tick_c;
  logic            mtime_wr_c;
  logic [TW-1:0]   mtime_nxt_c;

`ifdef CLINT_PRESCALE_EN
  localparam int unsigned PCW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [PCW-1:0] pcnt;

  // Prescaler: mtime advances on the cycle the counter wraps back to 0.
  assign tick_c = (pcnt == PCW'(PRESCALE_DIV - 1));

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (tick_c || mtime_wr_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCW'(1);
    end
  end
`else
  // Without the prescaler PRESCALE_DIV has no effect.
  logic unused_prescale_div;
  assign unused_prescale_div = ^32'(PRESCALE_DIV);
  assign tick_c = 1'b1;
`endif

  // A write to either mtime half overrides that cycle's increment, carry included.
  always_comb begin
    mtime_wr_c  = (state == EXEC) && req_we && !req_addr[1];
    mtime_nxt_c = mtime + TW'(tick_c);
    if (mtime_wr_c) begin
      if (req_addr[0]) begin
        mtime_nxt_c = {req_wdata, mtime[DW-1:0]};
      end else begin
        mtime_nxt_c = {mtime[TW-1:DW], req_wdata};
      end
    end
  end

  assign mtime_lo = mtime[DW-1:0];
  assign mtime_hi = mtime[TW-1:DW];

  always_ff @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_s1    <= 1'b0;
      req_s2    <= 1'b0;
      req_seen  <= 1'b0;
      ack_tgl   <= 1'b0;
      rsp_rdata <= '0;
      rd_stage  <= '0;
      hi_snap   <= '0;
      snap_vld  <= 1'b0;
      timer_irq <= 1'b0;
      mtime     <= '0;
      mtimecmp  <= '1;
    end else begin
      req_s1    <= req_tgl;
      req_s2    <= req_s1;
      mtime     <= mtime_nxt_c;
      timer_irq <= (mtime >= mtimecmp);
      case (state)
        IDLE: begin
          if (req_s2 != req_seen) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= ACK;
          if (req_we) begin
            rd_stage <= '0;
            snap_vld <= 1'b0;
            if (req_addr == 2'd2) begin
              mtimecmp[DW-1:0] <= req_wdata;
            end else if (req_addr == 2'd3) begin
              mtimecmp[TW-1:DW] <= req_wdata;
            end
          end else begin
            case (req_addr)
              2'd0: begin
                rd_stage <= mtime[DW-1:0];
                hi_snap  <= mtime[TW-1:DW];
                snap_vld <= 1'b1;
              end
              2'd1: begin
                rd_stage <= snap_vld ? hi_snap : mtime[TW-1:DW];
                snap_vld <= 1'b0;
              end
              2'd2:    rd_stage <= mtimecmp[DW-1:0];
              default: rd_stage <= mtimecmp[TW-1:DW];
            endcase
          end
        end
        ACK: begin
          // Retire exactly one request edge, so an edge that landed during
          // EXEC/ACK is still pending on return to IDLE.
          state     <= IDLE;
          req_seen  <= ~req_seen;
          ack_tgl   <= ~req_seen;
          rsp_rdata <= rd_stage;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer_resp.sv
// Bench for clint_timer_resp: vector table, corner sequences and random traffic
// checked against a cycle-level reference of the timer registers.
module tb_clint_timer_resp;

  localparam int unsigned PDIV = 4;

  logic        clk_timer = 1'b0;
  logic        rst       = 1'b0;
  logic        req_tgl   = 1'b0;
  logic        req_we    = 1'b0;
  logic [1:0]  req_addr  = 2'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        ack_tgl;
  logic [31:0] rsp_rdata;
  logic        timer_irq;
  logic [31:0] mtime_lo;
  logic [31:0] mtime_hi;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  clint_timer_resp #(.PRESCALE_DIV(PDIV)) dut (
    .clk_timer (clk_timer),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack_tgl   (ack_tgl),
    .rsp_rdata (rsp_rdata),
    .timer_irq (timer_irq),
    .mtime_lo  (mtime_lo),
    .mtime_hi  (mtime_hi)
  );

  always #5 clk_timer = ~clk_timer;

  // ---------------- reference model ----------------
  typedef struct {
    int         at;
    logic       we;
    logic [1:0] addr;
    logic [31:0] wd;
  } req_t;

  req_t        pend[$];
  logic [31:0] res_q[$];
  req_t        p;
  logic [63:0] m_time = 64'h0;
  logic [63:0] m_cmp  = '1;
  logic [63:0] m_nxt;
  logic [31:0] m_snap = 32'h0;
  logic [31:0] m_rd;
  logic        m_vld  = 1'b0;
  logic        m_irq  = 1'b0;
  logic        m_tick;
  int          ecnt   = 0;
  int          m_pcnt = 0;
  int          last_exec = -100;

  always @(posedge clk_timer or negedge rst) begin
    if (!rst) begin
      m_time = 64'h0; m_cmp = '1; m_snap = 32'h0; m_vld = 1'b0; m_irq = 1'b0;
      ecnt = 0; m_pcnt = 0;
      pend.delete(); res_q.delete();
    end else begin
      ecnt  = ecnt + 1;
      m_irq = (m_time >= m_cmp);
`ifdef CLINT_PRESCALE_EN
      m_tick = (m_pcnt == PDIV - 1);
      m_pcnt = m_tick ? 0 : m_pcnt + 1;
`else
      m_tick = 1'b1;
`endif
      m_nxt = m_time + 64'(m_tick);
      if (pend.size() > 0 && pend[0].at == ecnt) begin
        p = pend.pop_front();
        m_rd = 32'h0;
        if (p.we) begin
          m_vld = 1'b0;
          case (p.addr)
            2'd0: begin m_nxt = (m_time & 64'hFFFF_FFFF_0000_0000) | 64'(p.wd); m_pcnt = 0; end
            2'd1: begin m_nxt = (m_time & 64'h0000_0000_FFFF_FFFF) | ({32'h0, p.wd} << 32); m_pcnt = 0; end
            2'd2: m_cmp = (m_cmp & 64'hFFFF_FFFF_0000_0000) | 64'(p.wd);
            default: m_cmp = (m_cmp & 64'h0000_0000_FFFF_FFFF) | ({32'h0, p.wd} << 32);
          endcase
        end else begin
          case (p.addr)
            2'd0: begin m_rd = 32'(m_time); m_snap = 32'(m_time >> 32); m_vld = 1'b1; end
            2'd1: begin m_rd = m_vld ? m_snap : 32'(m_time >> 32); m_vld = 1'b0; end
            2'd2: m_rd = 32'(m_cmp);
            default: m_rd = 32'(m_cmp >> 32);
          endcase
        end
        res_q.push_back(m_rd);
      end
      m_time = m_nxt;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk_timer) begin
    if (chk_en) begin
      chk("mtime", {mtime_hi, mtime_lo}, m_time);
      chk("irq", 64'(timer_irq), 64'(m_irq));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_timer);
      #1;
    end
  endtask

  // Schedule the reference access: 4th edge after the toggle, or 3 edges after the previous access.
  task automatic post(input logic we, input logic [1:0] addr, input logic [31:0] wd, output int ex);
    req_t r;
    ex = (ecnt + 4 > last_exec + 3) ? ecnt + 4 : last_exec + 3;
    last_exec = ex;
    r.at = ex; r.we = we; r.addr = addr; r.wd = wd;
    pend.push_back(r);
  endtask

  task automatic issue(input logic we, input logic [1:0] addr, input logic [31:0] wd, output int ex);
    post(we, addr, wd, ex);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_tgl   = ~req_tgl;
  endtask

  task automatic wait_ack(input logic tgt, input int exp_edge, input string nm);
    int n;
    n = 0;
    while (ack_tgl !== tgt && n < 40) begin
      step(1);
      n++;
    end
    if (ack_tgl !== tgt) begin
      total++; bad++;
      $display("FAIL %s_ack: timeout, ack_tgl=%b expected %b", nm, ack_tgl, tgt);
    end else begin
      chk({nm, "_lat"}, 64'(ecnt), 64'(exp_edge));
    end
  endtask

  task automatic chk_res(input string nm, input logic [31:0] rd);
    logic [31:0] e;
    if (res_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_rd: no reference result, got %h", nm, rd);
    end else begin
      e = res_q.pop_front();
      chk({nm, "_rd"}, 64'(rd), 64'(e));
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                     input string nm, output logic [31:0] rd);
    int ex;
    issue(we, addr, wd, ex);
    wait_ack(req_tgl, ex + 1, nm);
    rd = rsp_rdata;
    chk_res(nm, rd);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        use_model;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] rd;
    logic [31:0] x_lo;
    logic [63:0] irq_mt;
    logic        lv1, lv2;
    logic [31:0] rd1;
    int          ex1, ex2, ex, n;

    tbl[0]  = '{1'b1, 2'd3, 32'h0000_0000, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 2'd2, 32'h0000_1234, 32'h0,         1'b0};
    tbl[2]  = '{1'b0, 2'd2, 32'h0,         32'h0000_1234, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[5]  = '{1'b0, 2'd0, 32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b0, 2'd1, 32'h0,         32'h0,         1'b1};
    tbl[7]  = '{1'b0, 2'd1, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{1'b1, 2'd3, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 2'd3, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[11] = '{1'b0, 2'd3, 32'h0,         32'hFFFF_FFFF, 1'b0};

    // Reset state and idle counting.
    step(3);
    chk("rst_mtime", {mtime_hi, mtime_lo}, 64'h0);
    chk("rst_ack", 64'(ack_tgl), 64'h0);
    chk("rst_rdata", 64'(rsp_rdata), 64'h0);
    chk("rst_irq", 64'(timer_irq), 64'h0);
    rst = 1'b1;
    last_exec = -100;
    chk_en = 1'b1;
    step(10);
`ifdef CLINT_PRESCALE_EN
    chk("idle10_mtime", {mtime_hi, mtime_lo}, 64'd2);
    step(30);
    chk("idle40_mtime", {mtime_hi, mtime_lo}, 64'd10);
`else
    chk("idle10_mtime", {mtime_hi, mtime_lo}, 64'd10);
`endif
    chk("idle_irq", 64'(timer_irq), 64'h0);
    chk("idle_ack", 64'(ack_tgl), 64'h0);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wd, $sformatf("vec%0d", i), rd);
      if (!tbl[i].use_model) chk($sformatf("vec%0d_const", i), 64'(rd), 64'(tbl[i].exp));
    end

    // Compare threshold at 20: interrupt rises one cycle after mtime reaches it, falls after a raising write.
    txn(1'b1, 2'd2, 32'd20, "cmp_lo20", rd);
    txn(1'b1, 2'd1, 32'h0, "mt_hi0", rd);
    txn(1'b1, 2'd0, 32'h0, "mt_lo0", rd);
    txn(1'b1, 2'd3, 32'h0, "cmp_hi0", rd);
    chk("irq_pre", 64'(timer_irq), 64'h0);
    n = 0;
    while (timer_irq !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
`ifdef CLINT_PRESCALE_EN
    irq_mt = 64'd20;
`else
    irq_mt = 64'd21;
`endif
    chk("irq_rise", 64'(timer_irq), 64'h1);
    chk("irq_rise_mtime", {mtime_hi, mtime_lo}, irq_mt);
    txn(1'b1, 2'd2, 32'hFFFF_FFFF, "cmp_max", rd);
    chk("irq_fall", 64'(timer_irq), 64'h0);

    // hi_snap keeps the pre-carry upper half across a low-word wrap.
`ifdef CLINT_PRESCALE_EN
    x_lo = 32'hFFFF_FFFE;
`else
    x_lo = 32'hFFFF_FFF8;
`endif
    txn(1'b1, 2'd1, 32'h0, "snap_whi", rd);
    txn(1'b1, 2'd0, x_lo, "snap_wlo", rd);
    txn(1'b0, 2'd0, 32'h0, "snap_rd0", rd);
    step(5);
    txn(1'b0, 2'd1, 32'h0, "snap_rd1", rd);
    chk("snap_hi_val", 64'(rd), 64'h0);
    chk("snap_live_hi", 64'(mtime_hi), 64'h1);

    // Two toggles two cycles apart: both acknowledged, in order.
    issue(1'b0, 2'd0, 32'h0, ex1);
    lv1 = req_tgl;
    step(2);
    issue(1'b0, 2'd0, 32'h0, ex2);
    lv2 = req_tgl;
    wait_ack(lv1, ex1 + 1, "dbl1");
    rd1 = rsp_rdata;
    chk_res("dbl1", rd1);
    wait_ack(lv2, ex2 + 1, "dbl2");
    chk_res("dbl2", rsp_rdata);
    chk("dbl_order", 64'(rsp_rdata > rd1), 64'h1);

    // Reset during EXEC aborts the access; the pending toggle is serviced after release.
    if (req_tgl) txn(1'b0, 2'd2, 32'h0, "align", rd);
    issue(1'b0, 2'd2, 32'h0, ex);
    step(3);
    rst = 1'b0;
    #1;
    chk("arst_mtime", {mtime_hi, mtime_lo}, 64'h0);
    chk("arst_ack", 64'(ack_tgl), 64'h0);
    chk("arst_rdata", 64'(rsp_rdata), 64'h0);
    chk("arst_irq", 64'(timer_irq), 64'h0);
    step(2);
    rst = 1'b1;
    last_exec = -100;
    post(1'b0, 2'd2, 32'h0, ex);
    wait_ack(1'b1, ex + 1, "rst_pend");
    chk_res("rst_pend", rsp_rdata);
    chk("rst_pend_val", 64'(rsp_rdata), 64'hFFFF_FFFF);

    // Random traffic against the reference.
    for (int i = 0; i < 80; i++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
          $sformatf("rnd%0d", i), rd);
      step($urandom_range(0, 3));
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
